spec_free_list: RTL

- Circular FIFO of free physical register tags. Sits directly upstream of the per-lane rename logic.
- Each cycle it presents the next DISPATCH_WIDTH free tags (free_phys_o) for the rename lanes to select from by prefix-count of valid destinations.
- Pops the number actually consumed; accepts tags released at commit.
- On recovery, restores its speculative head to the committed head.

---
 rtl/spec_free_list_pkg.sv | 19 +
 rtl/spec_free_list_popcount.sv | 17 +
 rtl/spec_free_list.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/spec_free_list_pkg.sv
// Shared sizing constants and types for the physical-register free list.
package spec_free_list_pkg;

    localparam int DISPATCH_WIDTH      = 4;
    localparam int COMMIT_WIDTH        = 4;
    localparam int SIZE_PHYSICAL_TABLE = 96;
    localparam int SIZE_RMT            = 32;
    localparam int FL_DEPTH            = SIZE_PHYSICAL_TABLE - SIZE_RMT;
    localparam int SIZE_PHYSICAL_LOG   = $clog2(SIZE_PHYSICAL_TABLE);
    localparam int FL_LOG              = $clog2(FL_DEPTH);
    localparam int DISPATCH_CNT_W      = $clog2(DISPATCH_WIDTH + 1);
    localparam int COMMIT_CNT_W        = $clog2(COMMIT_WIDTH + 1);

    typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_reg_t;
    // Pointers carry one extra wrap bit above the index.
    typedef logic [FL_LOG:0]              fl_ptr_t;
    typedef logic [FL_LOG+1:0]            fl_wide_t;

endpackage

// File: rtl/spec_free_list_popcount.sv
// Population count of a valid-bit vector.
module fl_popcount #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] bits_i,
    output logic [CNT_W-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CNT_W'(bits_i[i]);
        end
    end

endmodule

// File: rtl/spec_free_list.sv
// Circular free list of physical register tags with speculative/commit heads.
// Define FREELIST_CHECK_EN to add the sticky freeListError_o checker.
module spec_free_list
    import spec_free_list_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [DISPATCH_WIDTH-1:0]        logDestValid_i,
    input  logic                             renameFire_i,
    output phys_reg_t [DISPATCH_WIDTH-1:0]   free_phys_o,
    output logic                             freeListEmpty_o,
    input  logic [COMMIT_WIDTH-1:0]          releaseValid_i,
    input  phys_reg_t [COMMIT_WIDTH-1:0]     releasePhys_i,
    input  logic [COMMIT_WIDTH-1:0]          commitDestValid_i,
    input  logic                             recoverFlag_i,
`ifdef FREELIST_CHECK_EN
    output logic                             freeListError_o,
`endif
    output logic [FL_LOG:0]                  specCount_o
);

    phys_reg_t mem_q [FL_DEPTH];
    phys_reg_t mem_d [FL_DEPTH];
    fl_ptr_t   spec_head_q, spec_head_d;
    fl_ptr_t   commit_head_q, commit_head_d;
    fl_ptr_t   tail_q, tail_d;
    fl_ptr_t   spec_count;
    fl_ptr_t   wr_ptr;
    logic      list_empty;
    logic      pop_en;

    logic [DISPATCH_CNT_W-1:0] pop_cnt;
    logic [COMMIT_CNT_W-1:0]   push_cnt;
    logic [COMMIT_CNT_W-1:0]   commit_cnt;

    fl_popcount #(.WIDTH(DISPATCH_WIDTH)) u_pop_cnt (
        .bits_i  (logDestValid_i),
        .count_o (pop_cnt)
    );

    fl_popcount #(.WIDTH(COMMIT_WIDTH)) u_push_cnt (
        .bits_i  (releaseValid_i),
        .count_o (push_cnt)
    );

    fl_popcount #(.WIDTH(COMMIT_WIDTH)) u_commit_cnt (
        .bits_i  (commitDestValid_i),
        .count_o (commit_cnt)
    );

    // Stall decision uses registered pointers only, so releases never un-stall in the same cycle.
    always_comb begin
        spec_count = tail_q - spec_head_q;
        list_empty = spec_count < fl_ptr_t'(DISPATCH_WIDTH);
        pop_en     = renameFire_i & ~list_empty & ~recoverFlag_i;

        commit_head_d = commit_head_q + fl_ptr_t'(commit_cnt);
        tail_d        = tail_q + fl_ptr_t'(push_cnt);

        spec_head_d = spec_head_q;
        if (recoverFlag_i) begin
            spec_head_d = commit_head_d;
        end else if (pop_en) begin
            spec_head_d = spec_head_q + fl_ptr_t'(pop_cnt);
        end
    end

    // Compacting push: a running write pointer skips invalid release slots.
    always_comb begin
        mem_d  = mem_q;
        wr_ptr = tail_q;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (releaseValid_i[i]) begin
                mem_d[FL_LOG'(wr_ptr)] = releasePhys_i[i];
                wr_ptr = wr_ptr + fl_ptr_t'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            free_phys_o[i] = mem_q[FL_LOG'(spec_head_q + fl_ptr_t'(i))];
        end
        freeListEmpty_o = list_empty;
        specCount_o     = spec_count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < FL_DEPTH; k++) begin
                mem_q[k] <= phys_reg_t'(SIZE_RMT + k);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= fl_ptr_t'(FL_DEPTH);
        end else begin
            mem_q         <= mem_d;
            spec_head_q   <= spec_head_d;
            commit_head_q <= commit_head_d;
            tail_q        <= tail_d;
        end
    end

`ifdef FREELIST_CHECK_EN
    logic    error_q, error_d;
    logic    push_overflow, commit_overrun, bad_tag;
    fl_ptr_t occupancy;

    // Occupancy counts from the commit head: popped-but-uncommitted entries still hold slots.
    always_comb begin
        occupancy      = tail_q - commit_head_q;
        push_overflow  = ({1'b0, occupancy} + fl_wide_t'(push_cnt)) > fl_wide_t'(FL_DEPTH);
        commit_overrun = fl_ptr_t'(commit_cnt) > (spec_head_q - commit_head_q);
        bad_tag        = 1'b0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            if (releaseValid_i[i] && (releasePhys_i[i] >= phys_reg_t'(SIZE_PHYSICAL_TABLE))) begin
                bad_tag = 1'b1;
            end
        end
        error_d         = error_q | push_overflow | commit_overrun | bad_tag;
        freeListError_o = error_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n) begin
            if (push_overflow)  $error("spec_free_list: push overflow");
            if (commit_overrun) $error("spec_free_list: commit head overran speculative head");
            if (bad_tag)        $error("spec_free_list: released tag out of range");
        end
    end
`endif
`endif

endmodule
